// File: rtl/input_ctrl_pkg.sv
// input_ctrl_pkg: shared state encoding, default geometry and counter widths for the input buffer controller
package input_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam int DEF_NUM_BUF = 32;
  localparam int DEF_WORDS_PER_BUF = 7;
  localparam int DEF_ELEMS_PER_BUF = 14;
  localparam int BUF_W = $clog2(DEF_NUM_BUF);
  localparam int WORD_W = $clog2(DEF_WORDS_PER_BUF);
  // sized for the skewed drain length so both builds share one counter width
  localparam int DRAIN_W = $clog2(DEF_ELEMS_PER_BUF + DEF_NUM_BUF - 1);
endpackage

// File: rtl/input_skew_gen.sv
// input_skew_gen: maps the drain count to per-lane output enables and reports the last drain count
//   drain_cnt in  drain count the enables are computed for
//   stall     in  forces all enables low
//   out_en    out per-lane output enable
//   drain_max out last drain count (D-1)
//   INPUT_SKEW_EN defined: lane i is delayed by i cycles (diagonal wavefront), D = ELEMS+NUM_BUF-1
//   INPUT_SKEW_EN undefined: all lanes enabled together, D = ELEMS
module input_skew_gen import input_ctrl_pkg::*; #(
  parameter int NUM_BUF = DEF_NUM_BUF,
  parameter int ELEMS_PER_BUF = DEF_ELEMS_PER_BUF
) (
  input  logic [DRAIN_W-1:0] drain_cnt,
  input  logic               stall,
  output logic [NUM_BUF-1:0] out_en,
  output logic [DRAIN_W-1:0] drain_max
);
`ifdef INPUT_SKEW_EN
  assign drain_max = DRAIN_W'(ELEMS_PER_BUF + NUM_BUF - 2);
  for (genvar i = 0; i < NUM_BUF; i++) begin : g_lane
    logic signed [6:0] diff;
    assign diff = $signed(7'(drain_cnt)) - $signed(7'(i));
    assign out_en[i] = !stall && !diff[6] && diff <= 7'(ELEMS_PER_BUF - 1);
  end
`else
  assign drain_max = DRAIN_W'(ELEMS_PER_BUF - 1);
  assign out_en = {NUM_BUF{!stall && drain_cnt <= drain_max}};
`endif
endmodule

// File: rtl/input_array_ctrl.sv
// input_array_ctrl: loads a tile into the input buffer array word by word, then drains it towards the PE array
//   clk, rst (sync, active-high); start requests a tile in IDLE; stall freezes draining
//   s_valid/s_data/s_ready: input word handshake
//   buf_wdata/buf_fifo_en: registered write of each accepted word to one buffer (buffer-major)
//   buf_out_en: per-buffer output enable during drain; buf_nrst: one-cycle buffer clear after start
//   busy: not IDLE; done: one-cycle pulse at tile end
//   optional feature macro: INPUT_SKEW_EN (systolic skew of buf_out_en, in input_skew_gen)
module input_array_ctrl import input_ctrl_pkg::*; #(
  parameter int NUM_BUF = DEF_NUM_BUF,
  parameter int WORDS_PER_BUF = DEF_WORDS_PER_BUF,
  parameter int ELEMS_PER_BUF = DEF_ELEMS_PER_BUF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               s_valid,
  input  logic [31:0]        s_data,
  output logic               s_ready,
  output logic [31:0]        buf_wdata,
  output logic [NUM_BUF-1:0] buf_fifo_en,
  output logic [NUM_BUF-1:0] buf_out_en,
  output logic               buf_nrst,
  output logic               busy,
  output logic               done
);
  state_t state, state_d;
  logic [BUF_W-1:0] buf_cnt;
  logic [WORD_W-1:0] word_cnt;
  logic [DRAIN_W-1:0] drain_cnt, drain_d, drain_max;
  logic [NUM_BUF-1:0] out_en_d;
  logic hs, last_word, last_buf, go, gate, nrst_q;
  assign hs = s_valid & s_ready;
  assign go = state == IDLE && start;
  assign last_word = word_cnt == WORD_W'(WORDS_PER_BUF - 1);
  assign last_buf = buf_cnt == BUF_W'(NUM_BUF - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign buf_nrst = nrst_q & ~rst;
  always_comb begin
    state_d = state;
    drain_d = drain_cnt;
    case (state)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = hs && last_word && last_buf ? DRAIN : LOAD;
      DRAIN: begin
        state_d = !stall && drain_cnt == drain_max ? DONE : DRAIN;
        drain_d = !stall && drain_cnt != drain_max ? drain_cnt + 1'b1 : drain_cnt;
      end
      default: state_d = IDLE;
    endcase
  end
  // enables are computed for the count the next cycle will hold, so each lane's window lines up with drain_cnt
  assign gate = state_d != DRAIN || (state == DRAIN && stall);
  input_skew_gen #(.NUM_BUF(NUM_BUF), .ELEMS_PER_BUF(ELEMS_PER_BUF)) u_skew (
    .drain_cnt(drain_d),
    .stall(gate),
    .out_en(out_en_d),
    .drain_max(drain_max)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      buf_cnt <= '0;
      word_cnt <= '0;
      drain_cnt <= '0;
      s_ready <= 1'b0;
      buf_wdata <= '0;
      buf_fifo_en <= '0;
      buf_out_en <= '0;
      nrst_q <= 1'b1;
    end else begin
      state <= state_d;
      drain_cnt <= drain_d;
      s_ready <= state_d == LOAD;
      nrst_q <= !go;
      buf_out_en <= out_en_d;
      buf_fifo_en <= hs ? {{(NUM_BUF-1){1'b0}}, 1'b1} << buf_cnt : '0;
      if (hs) buf_wdata <= s_data;
      if (go) begin
        buf_cnt <= '0;
        word_cnt <= '0;
        drain_cnt <= '0;
      end else if (hs) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        if (last_word && !last_buf) buf_cnt <= buf_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_input_array_ctrl.sv
// tb_input_array_ctrl: scoreboard bench for input_array_ctrl (writes and drain enables checked by a monitor)
module tb_input_array_ctrl;
`ifdef INPUT_SKEW_EN
  localparam int D = 45;
`else
  localparam int D = 14;
`endif
  logic clk = 0, rst = 1, start = 0, stall = 0, s_valid = 0;
  logic [31:0] s_data = 0;
  logic s_ready, buf_nrst, busy, done;
  logic [31:0] buf_wdata, buf_fifo_en, buf_out_en;
  int pass_cnt = 0, total = 0;
  bit mon_on = 0;
  logic [31:0] wq_data[$], wq_en[$], oq[$];
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  input_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .buf_wdata(buf_wdata), .buf_fifo_en(buf_fifo_en), .buf_out_en(buf_out_en),
    .buf_nrst(buf_nrst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_vec(input int c);
    logic [31:0] v;
    for (int i = 0; i < 32; i++)
`ifdef INPUT_SKEW_EN
      v[i] = c >= i && c - i <= 13;
`else
      v[i] = 1'b1;
`endif
    return v;
  endfunction

  always @(negedge clk)
    if (mon_on) begin
      if (buf_fifo_en != 0) begin
        if (wq_data.size() == 0) chk("unexpected write", buf_fifo_en, 0);
        else begin
          chk("wdata", buf_wdata, wq_data.pop_front());
          chk("fifo_en", buf_fifo_en, wq_en.pop_front());
        end
      end
      if (buf_out_en != 0) begin
        if (oq.size() == 0) chk("unexpected out_en", buf_out_en, 0);
        else chk("out_en", buf_out_en, oq.pop_front());
      end
    end

  task automatic run_tile(input logic [31:0] base, input bit gaps, input bit stalls, input int abort_at);
    int k = 0, p = 0, ld = 0, cyc = 0, dc = 0, l0 = 0, l31 = 0, nrst_bad = 0;
    bit prev_st = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 1;
    chk("nrst after start", buf_nrst, 0);
    chk("busy after start", busy, 1);
    chk("s_ready in load", s_ready, 1);
    while (k < 224 && ld < 2000) begin
      if (ld > 0 && !buf_nrst) nrst_bad++;
      s_valid = gaps ? pat[p % 4] : 1'b1;
      p++;
      s_data = base + k;
      if (s_valid && s_ready) begin
        wq_data.push_back(base + k);
        wq_en.push_back(32'd1 << (k / 7));
        k++;
      end
      @(posedge clk); #1;
      ld++;
      cyc++;
      if (k == abort_at) begin
        rst = 1;
        s_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk); #1;
        chk("abort busy", busy, 0);
        chk("abort s_ready", s_ready, 0);
        chk("abort writes drained", wq_data.size(), 0);
        return;
      end
    end
    s_valid = 0;
    chk("load word count", k, 224);
    chk("nrst high during load", nrst_bad, 0);
    chk("s_ready in drain", s_ready, 0);
    for (int c = 0; c < D; c++) oq.push_back(exp_vec(c));
    while (!done && dc < 200) begin
      if (prev_st) chk("out_en after stall", buf_out_en, 0);
      l0 += buf_out_en[0];
      l31 += buf_out_en[31];
      stall = stalls && dc >= 5 && dc <= 7;
      prev_st = stall;
      @(posedge clk); #1;
      stall = 0;
      dc++;
      cyc++;
    end
    chk("done seen", done, 1);
    chk("start to done", cyc, 1 + ld + D + (stalls ? 3 : 0));
    chk("out_en in done", buf_out_en, 0);
    chk("lane0 window", l0, 14);
    chk("lane31 window", l31, 14);
    @(posedge clk); #1;
    chk("done one cycle", done, 0);
    chk("idle after done", busy, 0);
    chk("write queue empty", wq_data.size(), 0);
    chk("out queue empty", oq.size(), 0);
  endtask

  initial begin
    rst = 1;
    start = 1;
    s_valid = 1;
    s_data = 32'hdead;
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1;
    chk("rst s_ready", s_ready, 0);
    chk("rst fifo_en", buf_fifo_en, 0);
    chk("rst out_en", buf_out_en, 0);
    chk("rst wdata", buf_wdata, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst nrst", buf_nrst, 0);
    rst = 0;
    start = 0;
    s_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", busy, 0);
    chk("idle s_ready", s_ready, 0);
    chk("idle nrst", buf_nrst, 1);
    run_tile(32'h0, 0, 0, -1);
    run_tile(32'h1000, 1, 0, -1);
    run_tile(32'h2000, 0, 1, -1);
    run_tile(32'h3000, 0, 0, 100);
    run_tile(32'h4000, 0, 0, -1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
